// File: rtl/stack_seq_ctrl_if.sv
// Command/response handshake between the button decode logic and the stack sequencer.
interface stack_seq_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       done;
  logic       err;
  logic [7:0] result;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, done, err, result
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, done, err, result
  );
endinterface

// File: rtl/stack_seq_ctrl.sv
// Stack-calculator command sequencer: owns SPR/DAR and steps the single-port
// synchronous RAM through each command's read / modify / write sequence.
module stack_seq_ctrl (
  input  logic             clk,
  input  logic             rst,
  stack_seq_ctrl_if.slave  bus,
  output logic [6:0]       spr,
  output logic [6:0]       dar,
  output logic             empty,
  output logic             full,
  output logic [6:0]       mem_addr,
  output logic             mem_we,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata
);
  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_RD_B, S_LATCH, S_WRITE, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_PUSH    = 3'd0,
    OP_POP     = 3'd1,
    OP_ADD     = 3'd2,
    OP_SUB     = 3'd3,
    OP_TOP     = 3'd4,
    OP_CLEAR   = 3'd5,
    OP_DAR_INC = 3'd6,
    OP_DAR_DEC = 3'd7
  } op_e;

  state_e     state_q;
  op_e        op_q;
  logic [6:0] spr_q;
  logic [6:0] dar_q;
  logic [6:0] mem_addr_q;
  logic [7:0] result_q;
  logic [7:0] mem_wdata_q;
  logic [7:0] a_q;
  logic       done_q;
  logic       err_q;
  logic       mem_we_q;

  op_e        cmd_op;
  logic       reject;
  logic [6:0] spr_p1;
  logic [6:0] spr_p2;
  logic [6:0] dar_step;

  // Mod-256 arithmetic; B is the deeper entry, A the top of stack.
  function automatic logic [7:0] alu_result(input logic sub, input logic [7:0] b,
                                            input logic [7:0] a);
    return sub ? (b - a) : (b + a);
  endfunction

  always_comb begin
    cmd_op   = op_e'(bus.cmd_op);
    spr_p1   = spr_q + 7'd1;
    spr_p2   = spr_q + 7'd2;
    dar_step = (cmd_op == OP_DAR_DEC) ? (dar_q - 7'd1) : (dar_q + 7'd1);
    reject   = 1'b0;
    case (cmd_op)
      OP_PUSH:        reject = (spr_q == 7'h00);
      OP_POP, OP_TOP: reject = (spr_q == 7'h7F);
      OP_ADD, OP_SUB: reject = (spr_q > 7'h7D);
      default:        reject = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_PUSH;
      spr_q       <= 7'h7F;
      dar_q       <= 7'h00;
      mem_addr_q  <= 7'h00;
      result_q    <= 8'h00;
      mem_wdata_q <= 8'h00;
      a_q         <= 8'h00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q <= cmd_op;
            if (reject) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              case (cmd_op)
                OP_PUSH: begin
                  state_q     <= S_WRITE;
                  mem_addr_q  <= spr_q;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= bus.cmd_data;
                end
                OP_CLEAR: begin
                  state_q    <= S_DONE;
                  done_q     <= 1'b1;
                  spr_q      <= 7'h7F;
                  dar_q      <= 7'h00;
                  result_q   <= 8'h00;
                  mem_addr_q <= 7'h00;
                end
                OP_DAR_INC, OP_DAR_DEC: begin
                  state_q    <= S_RD_A;
                  dar_q      <= dar_step;
                  mem_addr_q <= dar_step;
                end
                default: begin
                  state_q    <= S_RD_A;
                  mem_addr_q <= spr_p1;
                end
              endcase
            end
          end
        end
        S_RD_A: begin
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            state_q    <= S_RD_B;
            mem_addr_q <= spr_p2;
          end else begin
            state_q <= S_LATCH;
          end
        end
        S_RD_B: begin
          a_q     <= mem_rdata;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          if (op_q == OP_ADD || op_q == OP_SUB) begin
            // Address is already spr+2, the slot the result overwrites.
            state_q     <= S_WRITE;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= alu_result(op_q == OP_SUB, mem_rdata, a_q);
          end else begin
            state_q  <= S_DONE;
            done_q   <= 1'b1;
            result_q <= mem_rdata;
            if (op_q == OP_POP) begin
              spr_q      <= spr_p1;
              dar_q      <= spr_p2;
              mem_addr_q <= spr_p2;
            end else if (op_q == OP_TOP) begin
              dar_q      <= spr_p1;
              mem_addr_q <= spr_p1;
            end
          end
        end
        S_WRITE: begin
          state_q  <= S_DONE;
          done_q   <= 1'b1;
          result_q <= mem_wdata_q;
          if (op_q == OP_PUSH) begin
            spr_q      <= spr_q - 7'd1;
            dar_q      <= spr_q;
            mem_addr_q <= spr_q;
          end else begin
            spr_q      <= spr_p1;
            dar_q      <= spr_p2;
            mem_addr_q <= spr_p2;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.result    = result_q;
  assign spr           = spr_q;
  assign dar           = dar_q;
  assign empty         = (spr_q == 7'h7F);
  assign full          = (spr_q == 7'h00);
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
endmodule

// File: doc/stack_seq_ctrl.md
# stack_seq_ctrl

Command sequencer for the 128x8 stack-calculator memory. It accepts one stack command at a time over a valid/ready handshake. It owns the stack pointer (SPR) and display address (DAR), and drives the single-port synchronous RAM (`memory`) through a multi-cycle state machine. It sits between the debounced-button decode logic and the RAM, and returns a result byte for `dispFSM`.

## Interface
- `clk` input 1: system clock; all logic on posedge.
- `rst` input 1: synchronous, active-high reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: high only in IDLE; a command is accepted when `cmd_valid & cmd_ready` at a posedge.
- `cmd_op` input 3: 0 PUSH, 1 POP, 2 ADD, 3 SUB, 4 TOP, 5 CLEAR, 6 DAR_INC, 7 DAR_DEC.
- `cmd_data` input 8: PUSH operand, sampled at acceptance.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: valid with `done`; command rejected, no state or memory change.
- `result` output 8: held from `done` until the next `done`.
- `spr` output 7: stack pointer (next free address).
- `dar` output 7: display address.
- `empty` output 1: `spr == 7'h7F`.
- `full` output 1: `spr == 7'h00`.
- `mem_addr` output 7, `mem_we` output 1, `mem_wdata` output 8: RAM port.
- `mem_rdata` input 8: RAM read data, valid the cycle after `mem_addr` is presented.

## Operation
- Reset values: `spr`=7F, `dar`=00, `result`=00, `done`=0, `err`=0, `mem_we`=0, `mem_wdata`=00, state IDLE (so `cmd_ready`=1).
- Stack grows downward. Top of stack is at `spr+1`; entry count is `7F - spr`; capacity is 127 entries (addresses 7F..01). Address 00 is never written by PUSH.
- States: IDLE, RD_A, RD_B, LATCH, WRITE, DONE.
- In IDLE and DONE, `mem_addr` = `dar`. `mem_we` is 1 only in WRITE.
- Error checks happen at acceptance. PUSH when full, POP/TOP when empty, or ADD/SUB with fewer than 2 entries (`spr > 7D`) go IDLE -> DONE with `err`=1. `result`, `spr`, `dar` and memory are unchanged.
- PUSH: IDLE -> WRITE (`mem_addr`=`spr`, `mem_wdata`=`cmd_data`) -> DONE.
  - On leaving WRITE: `spr`-=1, `dar`=old `spr`, `result`=`cmd_data`.
- POP: IDLE -> RD_A (`mem_addr`=`spr+1`) -> LATCH (capture A) -> DONE.
  - `result`=A, `spr`+=1, `dar`=new `spr`+1 (wraps to 00 when the stack becomes empty).
- TOP: same path as POP, but `spr` is unchanged and `dar`=`spr+1`.
- ADD/SUB: IDLE -> RD_A (addr `spr+1`) -> RD_B (addr `spr+2`, capture A=top) -> LATCH (capture B=next) -> WRITE (addr `spr+2`, data R) -> DONE.
  - ADD: R = (B + A) mod 256. SUB: R = (B - A) mod 256.
  - `spr`+=1, `dar`=new `spr`+1, `result`=R. No carry or borrow flag.
- CLEAR: IDLE -> DONE. `spr`=7F, `dar`=00, `result`=00. Memory is not erased.
- DAR_INC / DAR_DEC: `dar` ±1 mod 128 (7F+1 -> 00, 00-1 -> 7F) on acceptance. Then RD_A (addr = new `dar`) -> LATCH -> DONE with `result` = mem[new `dar`]. Never errors.
- `cmd_valid` outside IDLE is ignored (not queued). Inputs are sampled only on the acceptance edge.

## Timing
- Cycle 0 is the acceptance edge. `done` pulses in cycle N, and `cmd_ready` returns in cycle N+1.
- Latencies (N):
  - CLEAR and errors: 1.
  - PUSH: 2.
  - POP, TOP, DAR_INC, DAR_DEC: 3.
  - ADD, SUB: 5.
- Back-to-back: the earliest next acceptance is cycle N+1.
- Reset mid-operation: at the reset edge the state goes to IDLE and all registers take their reset values. `mem_we` is 0 from that edge onward, and the partial command is abandoned with no `done`.
  - A WRITE cycle is atomic. If reset is asserted during WRITE, that write still commits.
- Reset has priority over any command accepted in the same cycle.

## Test plan
- After reset: PUSH 0x05, then PUSH 0x03 -> `done` at +2 each; mem[7F]=05, mem[7E]=03; `spr`=7D; `result`=03; `dar`=7E.
- From that state, SUB -> `done` at +5, `result`=0x02, mem[7F]=02, `spr`=7E. Repeat with 03 then 05 pushed -> `result`=0xFE (wrap).
- PUSH 0xC8, PUSH 0x64, ADD -> `result`=0x2C, `spr`=7E, `err`=0.
- From reset: POP -> `err`=1 at +1, `spr`=7F. ADD with 1 entry -> `err`=1, mem[7F] untouched. 127 PUSHes, then a 128th PUSH -> `err`=1, mem[00] unwritten.
- `dar`=00, DAR_DEC -> `dar`=7F, `result`=mem[7F] at +3. DAR_INC from 7F -> `dar`=00.
- Assert `rst` during RD_B of an ADD -> no `done`, `spr`=7F, `cmd_ready`=1 next cycle, and memory contents are unchanged.
